// File: rtl/pipe_perf_monitor_if.sv
// Bundle between the CPU core (or bench) and the performance monitor.
// Carries run/event inputs, the counter read port and the status flags.
interface pipe_perf_monitor_if;
    logic        start_i;
    logic        stall_i;
    logic        flush_i;
    logic        retire_i;
    logic        clear_i;
    logic [2:0]  rd_addr_i;
    logic [31:0] rd_data_o;
    logic        halt_o;
    logic        running_o;

    modport master (
        output start_i, stall_i, flush_i, retire_i,
        output clear_i, rd_addr_i,
        input  rd_data_o, halt_o, running_o
    );

    modport slave (
        input  start_i, stall_i, flush_i, retire_i,
        input  clear_i, rd_addr_i,
        output rd_data_o, halt_o, running_o
    );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Performance monitor for the 5-stage core: counts run cycles, stalls,
// flushes and retirements, halts after a cycle budget, registered reads.
// Ports: clk_i, rst_i (sync, active-high), bus (slave side of the bundle).
module pipe_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_perf_monitor_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [32:0] MAX_C = 33'(MAX_CYCLES);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cyc_q, stl_q, fls_q, ret_q;
    logic [31:0]      rd_q, rd_nxt;
    logic             cnt_en;
    logic             hit;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             inc
    );
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    assign cnt_en = (state == RUN) && bus.start_i;

    // Budget reached on the edge that moves cycle from MAX-1 to MAX.
    assign hit = cnt_en && (MAX_CYCLES != 0) &&
                 ((33'(cyc_q) + 33'd1) == MAX_C);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start_i) state_nxt = RUN;
            RUN: begin
                if (!bus.start_i) state_nxt = IDLE;
                else if (hit)     state_nxt = DONE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux sees the current registers, so a read concurrent
    // with counting returns the pre-update value.
    always_comb begin
        rd_nxt = '0;
        unique case (bus.rd_addr_i)
            3'd0:    rd_nxt = 32'(cyc_q);
            3'd1:    rd_nxt = 32'(stl_q);
            3'd2:    rd_nxt = 32'(fls_q);
            3'd3:    rd_nxt = 32'(ret_q);
            3'd4:    rd_nxt = {29'b0, state == DONE,
                               state == RUN, state == IDLE};
            default: rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            state <= IDLE;
            cyc_q <= '0;
            stl_q <= '0;
            fls_q <= '0;
            ret_q <= '0;
            rd_q  <= '0;
        end else begin
            state <= state_nxt;
            rd_q  <= rd_nxt;
            if (cnt_en) begin
                cyc_q <= sat_inc(cyc_q, 1'b1);
                stl_q <= sat_inc(stl_q, bus.stall_i);
                fls_q <= sat_inc(fls_q, bus.flush_i);
                ret_q <= sat_inc(ret_q, bus.retire_i);
            end
        end
    end

    assign bus.rd_data_o = rd_q;
    assign bus.halt_o    = (state == DONE);
    assign bus.running_o = (state == RUN);

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: default build plus a 4-bit,
// unlimited-budget build for saturation.
module tb_pipe_perf_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_perf_monitor_if p0 ();
    pipe_perf_monitor_if p1 ();

    pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(64)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (p0.slave)
    );

    pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (p1.slave)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string tag,
                         input logic [2:0] a,
                         input logic [31:0] exp);
        p0.rd_addr_i = a;
        tick();
        chk(tag, p0.rd_data_o, exp);
    endtask

    task automatic ev0(input logic s, input logic f, input logic r);
        p0.stall_i  = s;
        p0.flush_i  = f;
        p0.retire_i = r;
    endtask

    logic halt_seen;

    initial begin
        p0.start_i = 0; p0.clear_i = 0; p0.rd_addr_i = 0;
        p1.start_i = 0; p1.clear_i = 0; p1.rd_addr_i = 0;
        ev0(0, 0, 0);
        p1.stall_i = 0; p1.flush_i = 0; p1.retire_i = 0;

        rst = 1;
        tick();
        rst = 0;
        chk("rst_rd", p0.rd_data_o, 0);
        chk("rst_halt", 32'(p0.halt_o), 0);
        chk("rst_run", 32'(p0.running_o), 0);
        rdchk("rst_status", 3'd4, 32'd1);

        // budget: 1 transition edge + 64 counting edges
        p0.rd_addr_i = 0;
        p0.start_i = 1;
        repeat (64) tick();
        chk("pre_done_halt", 32'(p0.halt_o), 0);
        chk("pre_done_run", 32'(p0.running_o), 1);
        tick();
        chk("done_halt", 32'(p0.halt_o), 1);
        chk("done_run", 32'(p0.running_o), 0);
        rdchk("done_cyc", 3'd0, 64);
        rdchk("done_stall", 3'd1, 0);
        rdchk("done_flush", 3'd2, 0);
        rdchk("done_retire", 3'd3, 0);

        // DONE is sticky and ignores events
        ev0(1, 1, 1);
        repeat (5) tick();
        ev0(0, 0, 0);
        p0.start_i = 0;
        rdchk("sticky_cyc", 3'd0, 64);
        rdchk("sticky_stall", 3'd1, 0);
        rdchk("status_done", 3'd4, 32'd4);
        rdchk("addr5", 3'd5, 0);
        rdchk("addr6", 3'd6, 0);
        rdchk("addr7", 3'd7, 0);
        rdchk("done_cyc2", 3'd0, 64);

        // clear zeroes rd_data on the same edge
        p0.clear_i = 1;
        tick();
        p0.clear_i = 0;
        chk("clr_rd", p0.rd_data_o, 0);
        chk("clr_halt", 32'(p0.halt_o), 0);
        rdchk("clr_status", 3'd4, 32'd1);

        // stalls/flushes with one overlapped cycle
        p0.rd_addr_i = 0;
        p0.start_i = 1;
        tick();
        ev0(1, 0, 0); tick();
        ev0(1, 0, 0); tick();
        ev0(1, 1, 0); tick();
        ev0(0, 1, 0); tick();
        ev0(0, 0, 0);
        p0.start_i = 0;
        tick();
        rdchk("t2_stall", 3'd1, 3);
        rdchk("t2_flush", 3'd2, 2);
        rdchk("t2_cyc", 3'd0, 4);
        rdchk("t2_retire", 3'd3, 0);

        // retire burst then pause
        p0.start_i = 1;
        tick();
        ev0(0, 0, 1);
        repeat (10) tick();
        ev0(0, 0, 0);
        p0.start_i = 0;
        tick();
        chk("pause_run", 32'(p0.running_o), 0);
        rdchk("pause_cyc", 3'd0, 14);
        chk("pause_run2", 32'(p0.running_o), 0);
        repeat (3) tick();
        rdchk("t3_retire", 3'd3, 10);
        chk("pause_run3", 32'(p0.running_o), 0);
        p0.start_i = 1;
        tick();
        chk("resume_run", 32'(p0.running_o), 1);
        repeat (2) tick();
        rdchk("rd_during_upd", 3'd0, 16);
        p0.start_i = 0;
        tick();
        rdchk("after_upd_cyc", 3'd0, 17);

        // clear mid-run with a stall pending
        p0.start_i = 1;
        tick();
        repeat (2) tick();
        ev0(1, 0, 0);
        p0.clear_i = 1;
        tick();
        p0.clear_i = 0;
        ev0(0, 0, 0);
        p0.start_i = 0;
        chk("clr2_rd", p0.rd_data_o, 0);
        chk("clr2_run", 32'(p0.running_o), 0);
        rdchk("clr2_cyc", 3'd0, 0);
        rdchk("clr2_stall", 3'd1, 0);
        rdchk("clr2_status", 3'd4, 32'd1);
        p0.start_i = 1;
        tick();
        chk("rerun", 32'(p0.running_o), 1);
        repeat (3) tick();
        p0.start_i = 0;
        tick();
        rdchk("rerun_cyc", 3'd0, 3);

        // 4-bit counters, no budget
        halt_seen = 0;
        p1.start_i = 1;
        p1.stall_i = 1;
        repeat (21) begin
            tick();
            halt_seen = halt_seen | p1.halt_o;
        end
        chk("sat_nohalt", 32'(halt_seen), 0);
        p1.rd_addr_i = 0;
        tick();
        chk("sat_cyc", p1.rd_data_o, 15);
        p1.rd_addr_i = 1;
        tick();
        chk("sat_stall", p1.rd_data_o, 15);
        p1.rd_addr_i = 4;
        tick();
        chk("sat_status", p1.rd_data_o, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
